// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the memory-access stage.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_RSVD  = 2'b11
  } mem_op_t;

  typedef enum logic [1:0] {
    SZ_1B = 2'b00,
    SZ_2B = 2'b01,
    SZ_4B = 2'b10,
    SZ_8B = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10
  } mem_state_t;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    logic [3:0] n;
    case (size)
      SZ_1B:   n = 4'd1;
      SZ_2B:   n = 4'd2;
      SZ_4B:   n = 4'd4;
      SZ_8B:   n = 4'd8;
      default: n = 4'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_stage_load_ext.sv
// Load data extension: right-aligned memory data to a 64-bit sign/zero-extended value.
module load_ext
  import mem_stage_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [63:0] ext
);

  // Select the accessed width and replicate the top bit only for signed loads
  always_comb begin
    case (size)
      SZ_1B:   ext = {{56{sign & rdata[7]}},  rdata[7:0]};
      SZ_2B:   ext = {{48{sign & rdata[15]}}, rdata[15:0]};
      SZ_4B:   ext = {{32{sign & rdata[31]}}, rdata[31:0]};
      SZ_8B:   ext = rdata;
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: captures ALU results, runs loads/stores over a req/gnt/rvalid port, retires one record each.
// Optional misalignment trap is built when MEM_ALIGN_CHECK_EN is defined.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exe_valid,
  input  logic [127:0]      exe_result,
  input  logic [63:0]       exe_rflags,
  input  logic [1:0]        exe_mem_op,
  input  logic [1:0]        exe_size,
  input  logic              exe_sign,
  input  logic [ADDR_W-1:0] exe_addr,
  input  logic [DATA_W-1:0] exe_st_data,
  input  logic [REG_W-1:0]  exe_dst,
  input  logic              exe_wb_en,
  output logic              mem_blocked,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_size,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic              wb_en,
  output logic [REG_W-1:0]  wb_reg,
  output logic [127:0]      wb_data,
  output logic [63:0]       wb_rflags,
  output logic              mem_fault
);

  typedef struct packed {
    logic [1:0]        op;
    logic [1:0]        size;
    logic              sign;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] st_data;
    logic [REG_W-1:0]  dst;
    logic              wb_en;
    logic [127:0]      result;
    logic [63:0]       rflags;
  } acc_t;

  mem_state_t        state_q, state_d;
  acc_t              acc_q, acc_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_en_q, wb_en_d;
  logic [REG_W-1:0]  wb_reg_q, wb_reg_d;
  logic [127:0]      wb_data_q, wb_data_d;
  logic [63:0]       wb_rflags_q, wb_rflags_d;

  logic              capture_s;
  logic              is_mem_s;
  logic              misalign_s;
  logic              done_s;
  logic [127:0]      done_data_s;
  logic [63:0]       ld_ext_s;

  load_ext u_load_ext (
    .rdata (mem_rdata[63:0]),
    .size  (acc_q.size),
    .sign  (acc_q.sign),
    .ext   (ld_ext_s)
  );

  assign is_mem_s = (exe_mem_op == OP_LOAD) || (exe_mem_op == OP_STORE);

`ifdef MEM_ALIGN_CHECK_EN
  logic [3:0] align_mask_s;
  logic       fault_q, fault_d;

  // Misaligned LOAD/STORE is trapped at capture and retires as a fault the next cycle
  always_comb begin
    align_mask_s = size_bytes(exe_size) - 4'd1;
    misalign_s   = |(exe_addr[3:0] & align_mask_s);
    fault_d      = (state_q == IDLE) && exe_valid && is_mem_s && misalign_s;
  end

  // Fault pulse register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign mem_fault = fault_q;
`else
  assign misalign_s = 1'b0;
  assign mem_fault  = 1'b0;
`endif

  // Next-state and retirement record
  always_comb begin
    state_d     = state_q;
    capture_s   = 1'b0;
    done_s      = 1'b0;
    done_data_s = 128'd0;
    wb_valid_d  = 1'b0;
    wb_en_d     = 1'b0;
    wb_reg_d    = '0;
    wb_data_d   = 128'd0;
    wb_rflags_d = 64'd0;
    case (state_q)
      IDLE: begin
        if (exe_valid) begin
          capture_s = 1'b1;
          if (is_mem_s && !misalign_s) begin
            state_d = REQ;
          end else begin
            // NONE retires immediately; a trapped access retires without a register write
            wb_valid_d  = 1'b1;
            wb_en_d     = exe_wb_en & ~is_mem_s;
            wb_reg_d    = exe_dst;
            wb_data_d   = is_mem_s ? 128'd0 : exe_result;
            wb_rflags_d = exe_rflags;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          if (acc_q.op == OP_STORE) begin
            state_d     = IDLE;
            done_s      = 1'b1;
            done_data_s = acc_q.result;
          end else if (mem_rvalid) begin
            state_d     = IDLE;
            done_s      = 1'b1;
            done_data_s = {64'd0, ld_ext_s};
          end else begin
            state_d = WAIT;
          end
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d     = IDLE;
          done_s      = 1'b1;
          done_data_s = {64'd0, ld_ext_s};
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (done_s) begin
      wb_valid_d  = 1'b1;
      wb_en_d     = acc_q.wb_en;
      wb_reg_d    = acc_q.dst;
      wb_data_d   = done_data_s;
      wb_rflags_d = acc_q.rflags;
    end else begin
      wb_valid_d  = wb_valid_d;
    end
  end

  // Access fields are captured only in IDLE, so the request stays stable until grant
  always_comb begin
    if (capture_s) begin
      acc_d.op      = exe_mem_op;
      acc_d.size    = exe_size;
      acc_d.sign    = exe_sign;
      acc_d.addr    = exe_addr;
      acc_d.st_data = exe_st_data;
      acc_d.dst     = exe_dst;
      acc_d.wb_en   = exe_wb_en;
      acc_d.result  = exe_result;
      acc_d.rflags  = exe_rflags;
    end else begin
      acc_d = acc_q;
    end
  end

  // State, captured access and writeback registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      wb_valid_q  <= 1'b0;
      wb_en_q     <= 1'b0;
      wb_reg_q    <= '0;
      wb_data_q   <= 128'd0;
      wb_rflags_q <= 64'd0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      wb_valid_q  <= wb_valid_d;
      wb_en_q     <= wb_en_d;
      wb_reg_q    <= wb_reg_d;
      wb_data_q   <= wb_data_d;
      wb_rflags_q <= wb_rflags_d;
    end
  end

  assign mem_blocked = (state_q != IDLE);
  assign mem_req     = (state_q == REQ);
  assign mem_we      = (acc_q.op == OP_STORE);
  assign mem_addr    = acc_q.addr;
  assign mem_size    = acc_q.size;
  assign mem_wdata   = acc_q.st_data;
  assign wb_valid    = wb_valid_q;
  assign wb_en       = wb_en_q;
  assign wb_reg      = wb_reg_q;
  assign wb_data     = wb_data_q;
  assign wb_rflags   = wb_rflags_q;

endmodule
